// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, FSM states, response codes.
// Pure declarations, no latency.
// No flow control of its own.
package mem_access_unit_pkg;

   // RV32I load/store funct3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic RESP_OK  = 1'b0;
   localparam logic RESP_ERR = 1'b1;

   // One-hot so that each state bit can feed a memory enable without decode logic
   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_RD   = 4'b0010,
      ST_WR   = 4'b0100,
      ST_RESP = 4'b1000
   } state_t;

   // funct3 values with no RV32I meaning for the given direction
   function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
      if (store)
         return (f3 > F3_W);
      else
         return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   // Halfwords need addr[0]==0, words need addr[1:0]==0
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b01:   return lo[0];
         2'b10:   return (lo != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   // Clears the low address bits that would make the access misaligned
   function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b01:   return {lo[1], 1'b0};
         2'b10:   return 2'b00;
         default: return lo;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/half lane of a memory word and sign/zero-extends it.
// Purely combinational, zero latency.
// No flow control.
module mem_load_extend
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      lane,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [XLEN-1:0] byte_shift;
   logic [XLEN-1:0] half_shift;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;

   // Lane select followed by extension chosen by funct3
   always_comb begin
      byte_shift = word >> {lane, 3'b000};
      half_shift = word >> {lane[1], 4'b0000};
      byte_sel   = byte_shift[7:0];
      half_sel   = half_shift[15:0];
      case (funct3)
         F3_B:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_BU:   data = {{(XLEN-8){1'b0}}, byte_sel};
         F3_H:    data = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_HU:   data = {{(XLEN-16){1'b0}}, half_sel};
         F3_W:    data = word;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: alignment check, sub-word stores by read-modify-write, extended load data.
// Accept-to-response: error 1, load 2, SW 2, SB/SH 3 cycles.
// One transaction at a time; reqReady low (stall high) from accept until back in IDLE.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int ALIGN_CHECK = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            reqValid,
   output logic            reqReady,
   input  logic            reqStore,
   input  logic [2:0]      reqFunct3,
   input  logic [XLEN-1:0] reqAddr,
   input  logic [XLEN-1:0] reqWData,
   input  logic [XLEN-1:0] reqPc,
   output logic            respValid,
   output logic            respErr,
   output logic [XLEN-1:0] respRData,
   output logic            stall,
   output logic [XLEN-1:0] memAddr,
   output logic            memReadEnable,
   input  logic [XLEN-1:0] memReadData,
   output logic            memWriteEnable,
   output logic [XLEN-1:0] memWriteData,
   output logic [XLEN-1:0] pcReadData
);

   state_t          state;
   state_t          state_nxt;
   logic            accept;
   logic            req_err;
   logic [XLEN-1:0] req_addr_eff;
   logic            op_store;
   logic [2:0]      op_f3;
   logic [15:0]     op_wdata;
   logic [XLEN-1:0] merged;
   logic [XLEN-1:0] lane_mask;
   logic [XLEN-1:0] lane_data;
   logic [4:0]      lane_shift;
   logic [XLEN-1:0] load_data;

   assign reqReady = (state == ST_IDLE);
   assign stall    = ~reqReady;
   assign accept   = reqValid & reqReady;

   // Request decode: error classification and the address actually sent to memory
   always_comb begin
      req_err      = f3_illegal(reqStore, reqFunct3);
      req_addr_eff = reqAddr;
      if (ALIGN_CHECK != 0)
         req_err = req_err | misaligned(reqFunct3, reqAddr[1:0]);
      else
         req_addr_eff[1:0] = align_lo(reqFunct3, reqAddr[1:0]);
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; sub-word stores detour through RD to fetch the word to merge
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (req_err)
                  state_nxt = ST_RESP;
               else if (reqStore && reqFunct3 == F3_W)
                  state_nxt = ST_WR;
               else
                  state_nxt = ST_RD;
            end
         end
         ST_RD:   state_nxt = op_store ? ST_WR : ST_RESP;
         ST_WR:   state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Merge the new byte/half into the word read back from memory
   always_comb begin
      lane_mask  = '0;
      lane_data  = '0;
      lane_shift = '0;
      if (op_f3 == F3_B) begin
         lane_shift = {memAddr[1:0], 3'b000};
         lane_mask  = {{(XLEN-8){1'b0}}, 8'hFF} << lane_shift;
         lane_data  = {{(XLEN-8){1'b0}}, op_wdata[7:0]} << lane_shift;
      end else begin
         lane_shift = {memAddr[1], 4'b0000};
         lane_mask  = {{(XLEN-16){1'b0}}, 16'hFFFF} << lane_shift;
         lane_data  = {{(XLEN-16){1'b0}}, op_wdata} << lane_shift;
      end
      merged = (memReadData & ~lane_mask) | lane_data;
   end

   mem_load_extend #(
      .XLEN(XLEN)
   ) u_load_extend (
      .word   (memReadData),
      .lane   (memAddr[1:0]),
      .funct3 (op_f3),
      .data   (load_data)
   );

   // Registered outputs; enables are flops of the next state so they never glitch
   always_ff @(posedge clk) begin
      if (reset) begin
         memReadEnable  <= 1'b0;
         memWriteEnable <= 1'b0;
         respValid      <= 1'b0;
         respErr        <= RESP_OK;
         respRData      <= '0;
         memAddr        <= '0;
         memWriteData   <= '0;
         pcReadData     <= '0;
         op_store       <= 1'b0;
         op_f3          <= F3_B;
         op_wdata       <= '0;
      end else begin
         memReadEnable  <= (state_nxt == ST_RD);
         memWriteEnable <= (state_nxt == ST_WR);
         respValid      <= (state_nxt == ST_RESP);
         if (accept) begin
            memAddr      <= req_addr_eff;
            pcReadData   <= reqPc;
            op_store     <= reqStore;
            op_f3        <= reqFunct3;
            op_wdata     <= reqWData[15:0];
            respErr      <= req_err ? RESP_ERR : RESP_OK;
            respRData    <= '0;
            memWriteData <= (reqStore && reqFunct3 == F3_W && !req_err) ? reqWData : '0;
         end
         if (state == ST_RD) begin
            if (op_store)
               memWriteData <= merged;
            else
               respRData <= load_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a word-wide behavioural memory.
// Directed vector table plus hand-written multi-cycle sequences.
// Requests are presented one at a time; the bench waits on respValid with a cycle bound.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        reqValid;
   logic        reqReady;
   logic        reqStore;
   logic [2:0]  reqFunct3;
   logic [31:0] reqAddr;
   logic [31:0] reqWData;
   logic [31:0] reqPc;
   logic        respValid;
   logic        respErr;
   logic [31:0] respRData;
   logic        stall;
   logic [31:0] memAddr;
   logic        memReadEnable;
   logic [31:0] memReadData;
   logic        memWriteEnable;
   logic [31:0] memWriteData;
   logic [31:0] pcReadData;

   int checks   = 0;
   int failures = 0;
   int we_count = 0;

   logic [31:0] mem [0:1023];
   logic        pre_we = 1'b0;
   logic [31:0] pre_addr = '0;
   logic [31:0] pre_data = '0;

   always #5 clk = ~clk;

   mem_access_unit #(.XLEN(32), .ALIGN_CHECK(1)) dut (
      .clk            (clk),
      .reset          (reset),
      .reqValid       (reqValid),
      .reqReady       (reqReady),
      .reqStore       (reqStore),
      .reqFunct3      (reqFunct3),
      .reqAddr        (reqAddr),
      .reqWData       (reqWData),
      .reqPc          (reqPc),
      .respValid      (respValid),
      .respErr        (respErr),
      .respRData      (respRData),
      .stall          (stall),
      .memAddr        (memAddr),
      .memReadEnable  (memReadEnable),
      .memReadData    (memReadData),
      .memWriteEnable (memWriteEnable),
      .memWriteData   (memWriteData),
      .pcReadData     (pcReadData)
   );

   // Behavioural memory: combinational read, write committed at the end of the enable cycle
   assign memReadData = mem[memAddr[11:2]];
   always @(posedge clk) begin
      if (memWriteEnable) begin
         mem[memAddr[11:2]] <= memWriteData;
         we_count <= we_count + 1;
      end else if (pre_we) begin
         mem[pre_addr[11:2]] <= pre_data;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(negedge clk);
      pre_we   = 1'b0;
   endtask

   // Presents one request and observes it to respValid (bounded); lat=0 means no response
   task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] pc,
                          output int lat, output logic err, output logic [31:0] rdata,
                          output int rdc, output int wrc, output logic [31:0] wad,
                          output logic [31:0] wdt, output logic [31:0] pcs);
      logic done;
      @(negedge clk);
      chk("ready_before_req", {31'd0, reqReady}, 32'd1);
      reqValid  = 1'b1;
      reqStore  = st;
      reqFunct3 = f3;
      reqAddr   = a;
      reqWData  = wd;
      reqPc     = pc;
      @(negedge clk);
      reqValid = 1'b0;
      lat = 0; err = 1'b0; rdata = '0; rdc = 0; wrc = 0; wad = '0; wdt = '0; pcs = '0;
      done = 1'b0;
      for (int c = 1; c <= 8 && !done; c++) begin
         if (memReadEnable) rdc++;
         if (memWriteEnable) begin
            wrc++;
            wad = memAddr;
            wdt = memWriteData;
            pcs = pcReadData;
         end
         if (respValid) begin
            lat   = c;
            err   = respErr;
            rdata = respRData;
            done  = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL resp_timeout: got no respValid expected one within 8 cycles");
      end
   endtask

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        e_err;
      int          e_lat;
      logic [31:0] e_rdata;
      int          e_rd;
      int          e_wr;
      logic [31:0] e_wdat;
   } vec_t;

   vec_t vecs [22];

   int          lat, rdc, wrc, accepts, we_base;
   logic        err;
   logic [31:0] rdata, wad, wdt, pcs;
   logic        seen_resp;

   initial begin
      // Word 0x10 holds 0x8000F0FF when the table starts
      vecs[0]  = '{0, 3'b000, 32'h10, 32'h0, 0, 2, 32'hFFFFFFFF, 1, 0, 32'h0};
      vecs[1]  = '{0, 3'b100, 32'h10, 32'h0, 0, 2, 32'h000000FF, 1, 0, 32'h0};
      vecs[2]  = '{0, 3'b001, 32'h12, 32'h0, 0, 2, 32'hFFFF8000, 1, 0, 32'h0};
      vecs[3]  = '{0, 3'b101, 32'h12, 32'h0, 0, 2, 32'h00008000, 1, 0, 32'h0};
      vecs[4]  = '{0, 3'b010, 32'h10, 32'h0, 0, 2, 32'h8000F0FF, 1, 0, 32'h0};
      vecs[5]  = '{0, 3'b000, 32'h11, 32'h0, 0, 2, 32'hFFFFFFF0, 1, 0, 32'h0};
      vecs[6]  = '{0, 3'b100, 32'h13, 32'h0, 0, 2, 32'h00000080, 1, 0, 32'h0};
      vecs[7]  = '{0, 3'b000, 32'h12, 32'h0, 0, 2, 32'h00000000, 1, 0, 32'h0};
      vecs[8]  = '{0, 3'b001, 32'h10, 32'h0, 0, 2, 32'hFFFFF0FF, 1, 0, 32'h0};
      vecs[9]  = '{0, 3'b010, 32'h13, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0};
      vecs[10] = '{1, 3'b001, 32'h11, 32'hFFFF, 1, 1, 32'h0, 0, 0, 32'h0};
      vecs[11] = '{0, 3'b001, 32'h11, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0};
      vecs[12] = '{1, 3'b010, 32'h12, 32'h1234, 1, 1, 32'h0, 0, 0, 32'h0};
      vecs[13] = '{0, 3'b011, 32'h10, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0};
      vecs[14] = '{1, 3'b011, 32'h10, 32'h1, 1, 1, 32'h0, 0, 0, 32'h0};
      vecs[15] = '{0, 3'b110, 32'h10, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0};
      vecs[16] = '{1, 3'b001, 32'h12, 32'h1234BEEF, 0, 3, 32'h0, 1, 1, 32'hBEEFF0FF};
      vecs[17] = '{0, 3'b010, 32'h10, 32'h0, 0, 2, 32'hBEEFF0FF, 1, 0, 32'h0};
      vecs[18] = '{1, 3'b000, 32'h10, 32'h00000055, 0, 3, 32'h0, 1, 1, 32'hBEEFF055};
      vecs[19] = '{0, 3'b100, 32'h10, 32'h0, 0, 2, 32'h00000055, 1, 0, 32'h0};
      vecs[20] = '{1, 3'b010, 32'h14, 32'h01234567, 0, 2, 32'h0, 0, 1, 32'h01234567};
      vecs[21] = '{0, 3'b101, 32'h16, 32'h0, 0, 2, 32'h00000123, 1, 0, 32'h0};

      reset = 1'b1; reqValid = 1'b0; reqStore = 1'b0; reqFunct3 = '0;
      reqAddr = '0; reqWData = '0; reqPc = '0;
      repeat (2) @(negedge clk);
      chk("rst_reqReady", {31'd0, reqReady}, 32'd1);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_respValid", {31'd0, respValid}, 32'd0);
      chk("rst_rdEn", {31'd0, memReadEnable}, 32'd0);
      chk("rst_wrEn", {31'd0, memWriteEnable}, 32'd0);
      chk("rst_memAddr", memAddr, 32'd0);
      reset = 1'b0;

      // SW writes the full word in a single write cycle
      run_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h400, lat, err, rdata, rdc, wrc, wad, wdt, pcs);
      chk("sw_lat", lat, 2);
      chk("sw_wr_cnt", wrc, 1);
      chk("sw_rd_cnt", rdc, 0);
      chk("sw_wr_addr", wad, 32'h10);
      chk("sw_wr_data", wdt, 32'hDEADBEEF);
      chk("sw_pc_trace", pcs, 32'h400);
      chk("sw_mem", mem[4], 32'hDEADBEEF);

      // SB read-modify-write into byte lane 2
      preload(32'h10, 32'h11223344);
      run_req(1, 3'b000, 32'h12, 32'h000000AA, 32'h404, lat, err, rdata, rdc, wrc, wad, wdt, pcs);
      chk("sb_lat", lat, 3);
      chk("sb_rd_cnt", rdc, 1);
      chk("sb_wr_cnt", wrc, 1);
      chk("sb_wr_data", wdt, 32'h11AA3344);
      chk("sb_mem", mem[4], 32'h11AA3344);

      // Vector table
      preload(32'h10, 32'h8000F0FF);
      for (int i = 0; i < 22; i++) begin
         run_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, 32'h800 + i,
                 lat, err, rdata, rdc, wrc, wad, wdt, pcs);
         chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].e_err});
         chk($sformatf("v%0d_lat", i), lat, vecs[i].e_lat);
         chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
         chk($sformatf("v%0d_rd_cnt", i), rdc, vecs[i].e_rd);
         chk($sformatf("v%0d_wr_cnt", i), wrc, vecs[i].e_wr);
         if (vecs[i].e_wr != 0) begin
            chk($sformatf("v%0d_wr_data", i), wdt, vecs[i].e_wdat);
            chk($sformatf("v%0d_wr_addr", i), wad, vecs[i].addr);
         end
      end

      // reqValid held high across a busy transaction is taken exactly once
      @(negedge clk);
      reqValid = 1'b1; reqStore = 1'b1; reqFunct3 = 3'b010;
      reqAddr = 32'h20; reqWData = 32'h5A5A5A5A; reqPc = 32'h900;
      accepts = 0;
      seen_resp = 1'b0;
      for (int c = 0; c < 10 && !seen_resp; c++) begin
         if (reqValid && reqReady) accepts++;
         if (respValid) seen_resp = 1'b1;
         else @(negedge clk);
      end
      reqValid = 1'b0;
      chk("hold_accepts", accepts, 1);
      chk("hold_resp_seen", {31'd0, seen_resp}, 32'd1);
      chk("hold_mem", mem[8], 32'h5A5A5A5A);

      // Store then load of the same word, back to back
      run_req(1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h904, lat, err, rdata, rdc, wrc, wad, wdt, pcs);
      chk("b2b_sw_lat", lat, 2);
      run_req(0, 3'b010, 32'h30, 32'h0, 32'h908, lat, err, rdata, rdc, wrc, wad, wdt, pcs);
      chk("b2b_lw_lat", lat, 2);
      chk("b2b_lw_data", rdata, 32'hCAFEF00D);

      // Reset during the RD cycle of an SH drops the pending write
      preload(32'h40, 32'h01020304);
      @(negedge clk);
      reqValid = 1'b1; reqStore = 1'b1; reqFunct3 = 3'b001;
      reqAddr = 32'h42; reqWData = 32'h0000FFFF; reqPc = 32'h90C;
      we_base = we_count;
      @(negedge clk);
      reqValid = 1'b0;
      chk("rmw_rd_phase", {31'd0, memReadEnable}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_reqReady", {31'd0, reqReady}, 32'd1);
      chk("mid_rst_wrEn", {31'd0, memWriteEnable}, 32'd0);
      chk("mid_rst_rdEn", {31'd0, memReadEnable}, 32'd0);
      chk("mid_rst_respValid", {31'd0, respValid}, 32'd0);
      chk("mid_rst_respErr", {31'd0, respErr}, 32'd0);
      chk("mid_rst_memAddr", memAddr, 32'd0);
      chk("mid_rst_wdata", memWriteData, 32'd0);
      chk("mid_rst_pc", pcReadData, 32'd0);
      chk("mid_rst_rdata", respRData, 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_rst_no_write", we_count, we_base);
      chk("mid_rst_mem", mem[16], 32'h01020304);
      run_req(0, 3'b101, 32'h42, 32'h0, 32'h910, lat, err, rdata, rdc, wrc, wad, wdt, pcs);
      chk("post_rst_lhu", rdata, 32'h00000102);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
